// File: rtl/vedic4_mul.sv
// Unsigned 4x4 Urdhva-Tiryagbhyam multiplier with a registered 8-bit product.
// Built from 2x2 Vedic cells and ripple chains of explicit half/full-adder cells.

module vedic4_ha (
    input  logic x,
    input  logic y,
    output logic s,
    output logic co
);
    assign s  = x ^ y;
    assign co = x & y;
endmodule

module vedic4_fa (
    input  logic x,
    input  logic y,
    input  logic ci,
    output logic s,
    output logic co
);
    assign s  = x ^ y ^ ci;
    assign co = (x & y) | (ci & (x ^ y));
endmodule

module vedic4_cell2 (
    input  logic [1:0] a,
    input  logic [1:0] b,
    output logic [3:0] p
);
    logic c1;

    assign p[0] = a[0] & b[0];
    vedic4_ha u_ha_lo (.x(a[1] & b[0]), .y(a[0] & b[1]), .s(p[1]), .co(c1));
    vedic4_ha u_ha_hi (.x(a[1] & b[1]), .y(c1),          .s(p[2]), .co(p[3]));
endmodule

module vedic4_mul (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] a,
    input  logic [3:0] b,
    output logic [7:0] c
);
    logic [3:0] q0, q1, q2, q3;
    logic [4:0] s1, s2;
    logic [3:0] k1, k2;
    logic [2:0] k3;
    logic [3:0] hi;
    logic [7:0] prod;

    vedic4_cell2 u_q0 (.a(a[1:0]), .b(b[1:0]), .p(q0));
    vedic4_cell2 u_q1 (.a(a[3:2]), .b(b[1:0]), .p(q1));
    vedic4_cell2 u_q2 (.a(a[1:0]), .b(b[3:2]), .p(q2));
    vedic4_cell2 u_q3 (.a(a[3:2]), .b(b[3:2]), .p(q3));

    // s1 = q1 + q2, the two crosswise partial products.
    vedic4_ha u_s1_0 (.x(q1[0]), .y(q2[0]),             .s(s1[0]), .co(k1[0]));
    vedic4_fa u_s1_1 (.x(q1[1]), .y(q2[1]), .ci(k1[0]), .s(s1[1]), .co(k1[1]));
    vedic4_fa u_s1_2 (.x(q1[2]), .y(q2[2]), .ci(k1[1]), .s(s1[2]), .co(k1[2]));
    vedic4_fa u_s1_3 (.x(q1[3]), .y(q2[3]), .ci(k1[2]), .s(s1[3]), .co(k1[3]));
    assign s1[4] = k1[3];

    // s2 = s1 + q0[3:2]; max 18 + 3 = 21, so bit 4 never carries out.
    vedic4_ha u_s2_0 (.x(s1[0]), .y(q0[2]),             .s(s2[0]), .co(k2[0]));
    vedic4_fa u_s2_1 (.x(s1[1]), .y(q0[3]), .ci(k2[0]), .s(s2[1]), .co(k2[1]));
    vedic4_ha u_s2_2 (.x(s1[2]), .y(k2[1]),             .s(s2[2]), .co(k2[2]));
    vedic4_ha u_s2_3 (.x(s1[3]), .y(k2[2]),             .s(s2[3]), .co(k2[3]));
    assign s2[4] = s1[4] ^ k2[3];

    // Upper nibble = q3 + s2[4:2]; the product is at most 225, so bit 3 needs no carry out.
    vedic4_ha u_hi_0 (.x(q3[0]), .y(s2[2]),             .s(hi[0]), .co(k3[0]));
    vedic4_fa u_hi_1 (.x(q3[1]), .y(s2[3]), .ci(k3[0]), .s(hi[1]), .co(k3[1]));
    vedic4_fa u_hi_2 (.x(q3[2]), .y(s2[4]), .ci(k3[1]), .s(hi[2]), .co(k3[2]));
    assign hi[3] = q3[3] ^ k3[2];

    assign prod = {hi, s2[1:0], q0[1:0]};

    // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            c <= 8'h00;
        end else begin
            c <= prod;
        end
    end
endmodule

// File: tb/tb_vedic4_mul.sv
// Self-checking bench for vedic4_mul: directed table, async reset cases,
// a random pipelined stream and an exhaustive sweep against a*b.

module tb_vedic4_mul;
    logic       clk;
    logic       rst_n;
    logic [3:0] a;
    logic [3:0] b;
    logic [7:0] c;

    int n_checks;
    int n_fails;

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic [7:0] exp;
    } vec_t;

    vec_t vecs[10];

    vedic4_mul dut (
        .clk   (clk),
        .rst_n (rst_n),
        .a     (a),
        .b     (b),
        .c     (c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [7:0] ref_mul(input logic [3:0] x, input logic [3:0] y);
        int unsigned p;
        p = int'(x) * int'(y);
        return p[7:0];
    endfunction

    task automatic check(input string name, input logic [7:0] actual, input logic [7:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fails++;
            $display("FAIL %s: got %h expected %h (a=%0d b=%0d) at %0t", name, actual, expected, a, b, $time);
        end
    endtask

    task automatic drive_and_capture(input logic [3:0] x, input logic [3:0] y);
        @(negedge clk);
        a = x;
        b = y;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0] exp_prev;
        n_checks = 0;
        n_fails  = 0;

        vecs[0] = '{4'd0,  4'd0,  8'h00};
        vecs[1] = '{4'd2,  4'd2,  8'h04};
        vecs[2] = '{4'd8,  4'd1,  8'h08};
        vecs[3] = '{4'd2,  4'd10, 8'h14};
        vecs[4] = '{4'd3,  4'd9,  8'h1B};
        vecs[5] = '{4'd5,  4'd9,  8'h2D};
        vecs[6] = '{4'd0,  4'd15, 8'h00};
        vecs[7] = '{4'd15, 4'd1,  8'h0F};
        vecs[8] = '{4'd1,  4'd15, 8'h0F};
        vecs[9] = '{4'd12, 4'd12, 8'h90};

        // Reset held with max operands while the clock runs.
        rst_n = 1'b1;
        a = 4'hF;
        b = 4'hF;
        #2 rst_n = 1'b0;
        #1 check("reset_async", c, 8'h00);
        repeat (3) @(posedge clk);
        #1 check("reset_held", c, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1 check("reset_release_first_edge", c, 8'hE1);

        // Directed and corner table.
        for (int i = 0; i < 10; i++) begin
            drive_and_capture(vecs[i].a, vecs[i].b);
            check($sformatf("table[%0d]", i), c, vecs[i].exp);
        end

        // Async reset while a nonzero product is held.
        drive_and_capture(4'd5, 4'd9);
        check("pre_reset_value", c, 8'h2D);
        #2 rst_n = 1'b0;
        #1 check("async_clear_between_edges", c, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        a = 4'd7;
        b = 4'd6;
        @(posedge clk);
        #1 check("reload_after_midstream_release", c, 8'd42);

        // Random pipelined stream: new operands every cycle, check one cycle later.
        @(negedge clk);
        a = 4'($urandom);
        b = 4'($urandom);
        exp_prev = ref_mul(a, b);
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            check("random_stream", c, exp_prev);
            a = 4'($urandom);
            b = 4'($urandom);
            exp_prev = ref_mul(a, b);
        end

        // Exhaustive sweep, streamed back to back.
        for (int x = 0; x < 16; x++) begin
            for (int y = 0; y < 16; y++) begin
                @(negedge clk);
                check("exhaustive_stream", c, exp_prev);
                a = 4'(x);
                b = 4'(y);
                exp_prev = ref_mul(a, b);
            end
        end
        @(negedge clk);
        check("exhaustive_last", c, exp_prev);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule
